// File: rtl/l2_arbiter.sv
// Arbitrates icache and dcache block transfers onto a single L2 port.
// Alternates ownership on ties and keeps one idle cycle between consecutive bursts.
module l2_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_ack,
    output logic              ic_done,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_gnt,
    output logic              dc_ack,
    output logic              dc_done,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic              l2_ack,
    input  logic [DATA_W-1:0] l2_rdata
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_BURST = 2'd1,
        DC_BURST = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat, beat_nxt;
    // 1 when dcache owned the most recent burst; a tie goes to the other side.
    logic             last_dc, last_dc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            beat    <= '0;
            last_dc <= 1'b0;
        end else begin
            state   <= state_nxt;
            beat    <= beat_nxt;
            last_dc <= last_dc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        last_dc_nxt = last_dc;
        ic_gnt      = 1'b0;
        ic_ack      = 1'b0;
        ic_done     = 1'b0;
        dc_gnt      = 1'b0;
        dc_ack      = 1'b0;
        dc_done     = 1'b0;
        l2_req      = 1'b0;
        l2_we       = 1'b0;
        l2_addr     = '0;
        l2_wdata    = '0;

        case (state)
            IDLE: begin
                beat_nxt = '0;
                if (ic_req && dc_req) begin
                    state_nxt = last_dc ? IC_BURST : DC_BURST;
                end else if (dc_req) begin
                    state_nxt = DC_BURST;
                end else if (ic_req) begin
                    state_nxt = IC_BURST;
                end
            end
            IC_BURST: begin
                ic_gnt  = 1'b1;
                l2_req  = ic_req;
                l2_addr = ic_addr;
                ic_ack  = l2_ack;
                ic_done = l2_ack && (beat == LAST_BEAT);
                // Completion and abort both release the port the same way.
                if (ic_done || !ic_req) begin
                    state_nxt   = IDLE;
                    beat_nxt    = '0;
                    last_dc_nxt = 1'b0;
                end else if (l2_ack) begin
                    beat_nxt = beat + CNT_W'(1);
                end
            end
            DC_BURST: begin
                dc_gnt   = 1'b1;
                l2_req   = dc_req;
                l2_we    = dc_we;
                l2_addr  = dc_addr;
                l2_wdata = dc_wdata;
                dc_ack   = l2_ack;
                dc_done  = l2_ack && (beat == LAST_BEAT);
                if (dc_done || !dc_req) begin
                    state_nxt   = IDLE;
                    beat_nxt    = '0;
                    last_dc_nxt = 1'b1;
                end else if (l2_ack) begin
                    beat_nxt = beat + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    assign ic_rdata = l2_rdata;
    assign dc_rdata = l2_rdata;

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, L2 word-address width.
REQ-002 Parameter: DATA_W, 32, L2 data width.
REQ-003 Parameter: WORDS_PER_BLOCK, 4, beats per block transfer; power of two, >=2.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 ic_req  in  1  icache block-transfer request; held high for the whole transfer.
REQ-007 ic_addr  in  ADDR_W  icache word address for the current beat.
REQ-008 ic_gnt  out  1  icache owns the L2 port.
REQ-009 ic_ack  out  1  current icache beat accepted by L2.
REQ-010 ic_done  out  1  one-cycle pulse on the last icache beat.
REQ-011 dc_req  in  1  dcache block-transfer request, i.e. flush or load; held high for the whole transfer.
REQ-012 dc_we  in  1  dcache beat is a write (flush).
REQ-013 dc_addr  in  ADDR_W  dcache word address for the current beat.
REQ-014 dc_wdata  in  DATA_W  dcache write data.
REQ-015 dc_gnt, dc_ack, dc_done  out  1 each  dcache equivalents of REQ-008 to REQ-010.
REQ-016 l2_req  out  1  L2 access strobe.
REQ-017 l2_we  out  1  L2 write enable.
REQ-018 l2_addr  out  ADDR_W  L2 address.
REQ-019 l2_wdata  out  DATA_W  L2 write data.
REQ-020 l2_ack  in  1  L2 beat complete; valid only while l2_req is high.
REQ-021 l2_rdata  in  DATA_W  L2 read data, broadcast unchanged to both requesters.
REQ-022 ic_rdata, dc_rdata  out  DATA_W  copies of l2_rdata.

Function
REQ-023 States: IDLE, IC_BURST, DC_BURST; state is registered.
REQ-024 Moore grant outputs: ic_gnt=1 only in IC_BURST; dc_gnt=1 only in DC_BURST.
REQ-025 IDLE with only one request: go to that requester's BURST state next cycle (grant latency 1 cycle).
REQ-026 IDLE with both requests: grant the requester that is not last_owner.
REQ-027 last_owner is a 1-bit register updated on every completed or aborted burst; reset value icache, so dcache wins the first tie.
REQ-028 In a BURST state: l2_req = owner req; l2_addr = owner addr.
REQ-029 In IC_BURST: l2_we=0 and l2_wdata=0. In DC_BURST: l2_we=dc_we and l2_wdata=dc_wdata.
REQ-030 In IDLE: l2_req, l2_we, l2_addr and l2_wdata are all 0.
REQ-031 Beat acks: ic_ack = l2_ack & IC_BURST; dc_ack = l2_ack & DC_BURST; the non-owner never sees an ack.
REQ-032 Beat counter, log2(WORDS_PER_BLOCK) bits: cleared on entry to a BURST state, incremented on each l2_ack.
REQ-033 On the ack whose counter value is WORDS_PER_BLOCK-1: assert owner done for that cycle (combinational with l2_ack), return to IDLE, set last_owner=owner.
REQ-034 Owner req dropping mid-burst (abort): return to IDLE next cycle, no done, counter cleared, last_owner=owner.
REQ-035 Mandatory one IDLE turnaround cycle between bursts, including back-to-back bursts by the same requester.
REQ-036 A non-owner request is held pending with no effect until IDLE.
REQ-037 l2_ack while in IDLE is ignored; no output changes and no counter change.

Reset
REQ-038 Reset forces: state=IDLE, counter=0, last_owner=icache; all outputs 0 the cycle after reset is sampled.
REQ-039 Reset mid-burst drops the grant without a done pulse; L2 tolerates the abandoned beat.

Verification
REQ-040 dc_req=1 alone, l2_ack on 4 consecutive cycles -> dc_gnt at cycle+1; dc_ack x4; dc_done only on 4th ack; IDLE next cycle.
REQ-041 ic_req and dc_req rise together after reset -> dcache served first; icache granted after dcache done plus 1 IDLE cycle; a later tie goes to dcache again.
REQ-042 DC_BURST with dc_we=1, dc_wdata=0xDEADBEEF, dc_addr=0x40 -> l2_we=1, l2_wdata=0xDEADBEEF, l2_addr=0x40; in IC_BURST l2_we=0 throughout.
REQ-043 dc_req dropped after 2 acks -> IDLE next cycle, no dc_done; next dcache burst needs 4 full acks for done.
REQ-044 reset asserted during IC_BURST after 1 ack -> all outputs 0 next cycle; fresh ic_req needs 4 acks for ic_done.
REQ-045 Stray l2_ack in IDLE, then dc_req -> counter unaffected; done on 4th granted ack.
